serial_feeder: RTL and testbench

- Upstream stage of the shift-register/counter/adder datapath.
- Accepts bytes over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte onto the 1-bit `d` line, then strobes `EN`/`inc` for one cycle so the downstream counters capture the fully shifted byte.
- Produces every control input the datapath consumes: `d`, `EN`, `inc`.

---
 rtl/serial_feeder.sv | 194 +++++++++++++++++++
 tb/tb_serial_feeder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_feeder.sv
`default_nettype none
// ============================================================================
// Module   : serial_feeder
// Brief    : Byte FIFO plus serialiser driving d/EN/inc of the downstream
//            shift-register/counter datapath. Optional pause input via
//            macro FEEDER_PAUSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module serial_feeder #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                            clk,
    input  logic                            res,
    input  logic [DATA_W-1:0]               in_data,
    input  logic                            in_inc,
    input  logic                            in_valid,
`ifdef FEEDER_PAUSE_EN
    input  logic                            pause,
`endif
    output logic                            in_ready,
    output logic                            d,
    output logic                            EN,
    output logic                            inc,
    output logic                            busy,
    output logic                            frame_done,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;
    localparam int c_cnt_w = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_lvl_w-1:0] c_full     = c_lvl_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_STROBE = 2'd2
    } state_t;

    logic [DATA_W:0]      r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wptr;
    logic [c_ptr_w-1:0]   r_rptr;
    logic [c_lvl_w-1:0]   r_level;
    logic [DATA_W:0]      w_head;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_shift;
    logic                 w_pause;
    logic                 w_err;
    logic                 w_bit;
    logic [DATA_W-1:0]    w_sr_next;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DATA_W-1:0]    r_sr;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_inc_lat;

    assign in_ready   = (r_level != c_full);
    assign fifo_level = r_level;
    assign busy       = (r_state != S_IDLE);
    assign w_push     = in_valid && in_ready;
    assign w_head     = r_mem[r_rptr];

    // ---------------------------------------------------------------- FIFO
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_inc, in_data};
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------- pause option
`ifdef FEEDER_PAUSE_EN
    logic r_err;

    assign w_pause = pause;
    assign w_err   = r_err;

    // A pause mid-frame desynchronises the downstream shifters, so remember it
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_err <= 1'b0;
        end else if (w_pop) begin
            r_err <= 1'b0;
        end else if ((r_state == S_SHIFT) && pause) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_pause = 1'b0;
    assign w_err   = 1'b0;
`endif

    // ----------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_level != '0) && !w_pause) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!w_pause) begin
                    w_shift = 1'b1;
                    if (r_cnt == c_last_bit) begin
                        w_state_nxt = S_STROBE;
                    end
                end
            end
            S_STROBE: begin
                if (r_level != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    assign w_bit     = (MSB_FIRST != 0) ? r_sr[DATA_W-1] : r_sr[0];
    assign w_sr_next = (MSB_FIRST != 0) ? (r_sr << 1) : (r_sr >> 1);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_sr      <= '0;
            r_cnt     <= '0;
            r_inc_lat <= 1'b0;
        end else if (w_pop) begin
            r_sr      <= w_head[DATA_W-1:0];
            r_inc_lat <= w_head[DATA_W];
            r_cnt     <= '0;
        end else if (w_shift) begin
            r_sr  <= w_sr_next;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // All datapath controls leave on flops, one cycle behind the state
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            d          <= 1'b0;
            EN         <= 1'b0;
            inc        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            d          <= w_shift ? w_bit : 1'b0;
            EN         <= (r_state == S_STROBE) && !w_err;
            frame_done <= (r_state == S_STROBE) && !w_err;
            if ((r_state == S_STROBE) && !w_err) begin
                inc <= r_inc_lat;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_feeder
// Brief    : Directed, table-driven self-checking bench for serial_feeder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_feeder;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_inc = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       d;
    logic       EN;
    logic       inc;
    logic       busy;
    logic       frame_done;
    logic [2:0] fifo_level;
`ifdef FEEDER_PAUSE_EN
    logic       pause = 1'b0;
`endif

    serial_feeder #(.DATA_W(8), .FIFO_DEPTH(4), .MSB_FIRST(1)) dut (
        .clk        (clk),
        .res        (res),
        .in_data    (in_data),
        .in_inc     (in_inc),
        .in_valid   (in_valid),
`ifdef FEEDER_PAUSE_EN
        .pause      (pause),
`endif
        .in_ready   (in_ready),
        .d          (d),
        .EN         (EN),
        .inc        (inc),
        .busy       (busy),
        .frame_done (frame_done),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Downstream model: an 8-bit shift register clocked every edge
    logic [7:0] q_model = 8'h00;
    always @(posedge clk) q_model <= {q_model[6:0], d};

    int         cyc = 0;
    logic [7:0] ev_q[$];
    logic       ev_inc[$];
    int         ev_t[$];
    logic       saw_full = 1'b0;
    logic       full_bad = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (res && EN) begin
            ev_q.push_back(q_model);
            ev_inc.push_back(inc);
            ev_t.push_back(cyc);
        end
        if (fifo_level == 3'd4) begin
            saw_full = 1'b1;
            if (in_ready) full_bad = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Call at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic push(input logic [7:0] dat, input logic iv, output int waited);
        waited = 0;
        in_data  = dat;
        in_inc   = iv;
        in_valid = 1'b1;
        while (!in_ready && waited < 60) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 60) chk("push_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts negedges after the accepting edge until EN is seen
    task automatic wait_en(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!EN && lat < 40);
        if (!EN) chk("en_timeout", 0, 1);
        else chk("frame_done_with_en", frame_done, 1'b1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        ev_q.delete();
        ev_inc.delete();
        ev_t.delete();
    endtask

    typedef struct {
        logic [7:0] data;
        logic       iv;
        logic [7:0] exp_q;
        logic       exp_inc;
    } vec_t;

    initial begin
        vec_t vecs[6];
        logic exp_d[1:12];
        int   w;
        int   lat;

        vecs[0] = '{8'h01, 1'b0, 8'h01, 1'b0};
        vecs[1] = '{8'h80, 1'b1, 8'h80, 1'b1};
        vecs[2] = '{8'hC3, 1'b1, 8'hC3, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h7E, 1'b1, 8'h7E, 1'b1};
        vecs[5] = '{8'h96, 1'b0, 8'h96, 1'b0};

        // Reset held with in_valid high
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) begin
            @(negedge clk);
            chk("rst_d", d, 1'b0);
            chk("rst_en", EN, 1'b0);
            chk("rst_ready", in_ready, 1'b1);
            chk("rst_level", fifo_level, 3'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        res      = 1'b1;
        idle_cycles(3);
        chk("post_rst_level", fifo_level, 3'd0);
        chk("post_rst_busy", busy, 1'b0);

        // Single byte A5, cycle-exact d sequence
        exp_d = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        push(8'hA5, 1'b1, w);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk($sformatf("a5_d[%0d]", i), d, exp_d[i]);
            chk($sformatf("a5_en[%0d]", i), EN, (i == 11) ? 1'b1 : 1'b0);
            if (i == 11) begin
                chk("a5_inc", inc, 1'b1);
                chk("a5_fd", frame_done, 1'b1);
                chk("a5_q", q_model, 8'hA5);
            end
        end
        idle_cycles(3);

        // Table-driven single frames from idle
        for (int v = 0; v < 6; v++) begin
            push(vecs[v].data, vecs[v].iv, w);
            wait_en(lat);
            chk($sformatf("vec%0d_lat", v), lat, 11);
            chk($sformatf("vec%0d_q", v), q_model, vecs[v].exp_q);
            chk($sformatf("vec%0d_inc", v), inc, vecs[v].exp_inc);
            idle_cycles(3);
            chk($sformatf("vec%0d_idle", v), busy, 1'b0);
        end

        // Back-to-back frames
        clear_events();
        push(8'h3C, 1'b0, w);
        push(8'hFF, 1'b1, w);
        idle_cycles(30);
        chk("b2b_count", ev_q.size(), 2);
        if (ev_q.size() == 2) begin
            chk("b2b_q0", ev_q[0], 8'h3C);
            chk("b2b_inc0", ev_inc[0], 1'b0);
            chk("b2b_q1", ev_q[1], 8'hFF);
            chk("b2b_inc1", ev_inc[1], 1'b1);
            chk("b2b_gap", ev_t[1] - ev_t[0], 9);
        end

        // Full FIFO: six pushes, the last held until a pop frees a slot
        clear_events();
        saw_full = 1'b0;
        full_bad = 1'b0;
        push(8'h11, 1'b1, w);
        push(8'h22, 1'b0, w);
        push(8'h33, 1'b1, w);
        push(8'h44, 1'b0, w);
        push(8'h55, 1'b1, w);
        push(8'h66, 1'b0, w);
        chk("full_held", (w > 0) ? 1 : 0, 1);
        chk("full_seen", saw_full, 1'b1);
        chk("full_ready_low", full_bad, 1'b0);
        idle_cycles(70);
        chk("full_count", ev_q.size(), 6);
        if (ev_q.size() == 6) begin
            chk("full_q0", ev_q[0], 8'h11);
            chk("full_q1", ev_q[1], 8'h22);
            chk("full_q2", ev_q[2], 8'h33);
            chk("full_q3", ev_q[3], 8'h44);
            chk("full_q4", ev_q[4], 8'h55);
            chk("full_q5", ev_q[5], 8'h66);
            chk("full_inc4", ev_inc[4], 1'b1);
            chk("full_inc5", ev_inc[5], 1'b0);
            chk("full_gap", ev_t[5] - ev_t[4], 9);
        end

        // Mid-frame reset after four bits of 81
        clear_events();
        push(8'h81, 1'b1, w);
        repeat (6) @(negedge clk);
        #2;
        res = 1'b0;
        #1;
        chk("mid_rst_d", d, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_level", fifo_level, 3'd0);
        chk("mid_rst_en", EN, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        res = 1'b1;
        idle_cycles(25);
        chk("mid_rst_no_en", ev_q.size(), 0);
        push(8'h42, 1'b0, w);
        wait_en(lat);
        chk("after_rst_lat", lat, 11);
        chk("after_rst_q", q_model, 8'h42);
        chk("after_rst_inc", inc, 1'b0);
        idle_cycles(3);

`ifdef FEEDER_PAUSE_EN
        // Pause for two cycles inside the frame of 5A suppresses its strobe
        clear_events();
        push(8'h5A, 1'b1, w);
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        pause = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("pause_d0", d, 1'b0);
        @(posedge clk); #1;
        pause = 1'b0;
        @(negedge clk);
        chk("pause_d1", d, 1'b0);
        @(posedge clk); #1;
        idle_cycles(25);
        chk("pause_no_en", ev_q.size(), 0);
        push(8'h11, 1'b0, w);
        wait_en(lat);
        chk("pause_next_lat", lat, 11);
        chk("pause_next_q", q_model, 8'h11);
        idle_cycles(3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
